// File: rtl/traffic_phase_controller_if.sv
// Sensor/actuator signal bundle for the intersection phase controller.
// The master side drives demand, enable and emergency; the slave side is the controller.
interface traffic_phase_controller_if;
    logic       en;
    logic [3:0] car_present;
    logic       emergency;
    logic [3:0] state;
    logic       almost_done;
    logic [1:0] lane_idx;

    modport master (
        output en, car_present, emergency,
        input  state, almost_done, lane_idx
    );

    modport slave (
        input  en, car_present, emergency,
        output state, almost_done, lane_idx
    );
endinterface

// File: rtl/traffic_phase_controller.sv
// Four-way intersection phase sequencer: demand-skipping green rotation with all-red
// clearance between phases and an emergency all-red override. All outputs registered.
//
//   state  | meaning
//   CLEAR  | all-red clearance; picks the next lane with demand when cnt reaches 0
//   GREEN  | one lane has right-of-way; almost_done over the final YELLOW_CYCLES
//   EMERG  | forced all-red while emergency is held
module traffic_phase_controller #(
    parameter int GREEN_CYCLES   = 8,
    parameter int YELLOW_CYCLES  = 2,
    parameter int ALL_RED_CYCLES = 2,
    parameter int CNT_W          = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    traffic_phase_controller_if.slave   bus
);

    typedef enum logic [1:0] {
        S_CLEAR = 2'd0,
        S_GREEN = 2'd1,
        S_EMERG = 2'd2
    } fsm_t;

    localparam logic [CNT_W-1:0] GRN_LOAD = CNT_W'(GREEN_CYCLES - 1);
    localparam logic [CNT_W-1:0] CLR_LOAD = CNT_W'(ALL_RED_CYCLES - 1);
    localparam logic [CNT_W-1:0] YEL_LIM  = CNT_W'(YELLOW_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    fsm_t             r_fsm;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_lane_idx;
    logic [3:0]       r_state;
    logic             r_almost_done;

    fsm_t             w_fsm_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [1:0]       w_lane_nxt;
    logic [3:0]       w_state_nxt;
    logic             w_ad_nxt;
    logic [1:0]       w_sel;
    logic [1:0]       w_cand;

    // Scan candidates from +4 down to +1 so the nearest lane with demand wins;
    // the current lane itself is only reached as the +4 candidate.
    always_comb begin
        w_sel  = r_lane_idx + 2'd1;
        w_cand = r_lane_idx;
        for (int k = 4; k >= 1; k--) begin
            w_cand = r_lane_idx + 2'(k);
            if (bus.car_present[w_cand]) begin
                w_sel = w_cand;
            end
        end
    end

    always_comb begin
        w_fsm_nxt   = r_fsm;
        w_cnt_nxt   = r_cnt;
        w_lane_nxt  = r_lane_idx;
        w_state_nxt = r_state;
        w_ad_nxt    = r_almost_done;

        if (bus.emergency) begin
            w_fsm_nxt   = S_EMERG;
            w_state_nxt = 4'b0000;
            w_ad_nxt    = 1'b0;
        end else if (bus.en) begin
            case (r_fsm)
                S_CLEAR: begin
                    w_state_nxt = 4'b0000;
                    w_ad_nxt    = 1'b0;
                    if (r_cnt != '0) begin
                        w_cnt_nxt = r_cnt - CNT_ONE;
                    end else begin
                        w_lane_nxt  = w_sel;
                        w_state_nxt = 4'b0001 << w_sel;
                        w_cnt_nxt   = GRN_LOAD;
                        w_ad_nxt    = (GRN_LOAD < YEL_LIM);
                        w_fsm_nxt   = S_GREEN;
                    end
                end
                S_GREEN: begin
                    if (r_cnt != '0) begin
                        w_cnt_nxt = r_cnt - CNT_ONE;
                        w_ad_nxt  = ((r_cnt - CNT_ONE) < YEL_LIM);
                    end else begin
                        w_state_nxt = 4'b0000;
                        w_ad_nxt    = 1'b0;
                        w_cnt_nxt   = CLR_LOAD;
                        w_fsm_nxt   = S_CLEAR;
                    end
                end
                S_EMERG: begin
                    w_state_nxt = 4'b0000;
                    w_ad_nxt    = 1'b0;
                    w_cnt_nxt   = CLR_LOAD;
                    w_fsm_nxt   = S_CLEAR;
                end
                default: begin
                    w_state_nxt = 4'b0000;
                    w_ad_nxt    = 1'b0;
                    w_cnt_nxt   = CLR_LOAD;
                    w_fsm_nxt   = S_CLEAR;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fsm         <= S_CLEAR;
            r_cnt         <= CLR_LOAD;
            r_lane_idx    <= 2'd3;
            r_state       <= 4'b0000;
            r_almost_done <= 1'b0;
        end else begin
            r_fsm         <= w_fsm_nxt;
            r_cnt         <= w_cnt_nxt;
            r_lane_idx    <= w_lane_nxt;
            r_state       <= w_state_nxt;
            r_almost_done <= w_ad_nxt;
        end
    end

    assign bus.state       = r_state;
    assign bus.almost_done = r_almost_done;
    assign bus.lane_idx    = r_lane_idx;

endmodule

// File: tb/tb_traffic_phase_controller.sv
// Directed bench for traffic_phase_controller with default timing (8 green, 2 yellow, 2 red).
// Inputs change on the falling edge; outputs are checked on the falling edge after each rise.
module tb_traffic_phase_controller;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    traffic_phase_controller_if bus ();

    traffic_phase_controller dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] st, input logic ad);
        checks++;
        assert ({bus.state, bus.almost_done} === {st, ad})
        else begin
            failures++;
            $error("FAIL %s state/almost_done got %b/%b expected %b/%b",
                   tag, bus.state, bus.almost_done, st, ad);
        end
    endtask

    task automatic chk_lane(input string tag, input logic [1:0] li);
        checks++;
        assert (bus.lane_idx === li)
        else begin
            failures++;
            $error("FAIL %s lane_idx got %0d expected %0d", tag, bus.lane_idx, li);
        end
    endtask

    task automatic step_chk(input string tag, input logic [3:0] st, input logic ad);
        @(posedge clk);
        @(negedge clk);
        chk(tag, st, ad);
    endtask

    // Full green phase (8 cycles, almost_done on the last 2) followed by 2 all-red cycles.
    task automatic green_phase(input string tag, input logic [3:0] st);
        for (int i = 0; i < 8; i++) step_chk(tag, st, (i >= 6));
        for (int i = 0; i < 2; i++) step_chk({tag, "_red"}, 4'b0000, 1'b0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        checks          = 0;
        failures        = 0;
        rst_n           = 1'b0;
        bus.en          = 1'b1;
        bus.car_present = 4'b1111;
        bus.emergency   = 1'b0;

        // Scenario 1: full rotation with all lanes demanding
        do_reset();
        chk("rst_state", 4'b0000, 1'b0);
        chk_lane("rst_lane", 2'd3);
        step_chk("s1_red0", 4'b0000, 1'b0);
        green_phase("s1_l1", 4'b0001);
        green_phase("s1_l2", 4'b0010);
        green_phase("s1_l3", 4'b0100);
        green_phase("s1_l4", 4'b1000);
        step_chk("s1_wrap", 4'b0001, 1'b0);
        chk_lane("s1_lane", 2'd0);

        // Scenario 2: only lane 3 demands; current lane 1 green finishes first
        bus.car_present = 4'b0100;
        for (int i = 1; i < 8; i++) step_chk("s2_l1_tail", 4'b0001, (i >= 6));
        for (int i = 0; i < 2; i++) step_chk("s2_red", 4'b0000, 1'b0);
        green_phase("s2_l3a", 4'b0100);
        chk_lane("s2_lane_a", 2'd2);
        green_phase("s2_l3b", 4'b0100);
        chk_lane("s2_lane_b", 2'd2);

        // Scenario 3: lanes 2 and 4 demand, starting from lane_idx=3
        bus.car_present = 4'b1010;
        do_reset();
        step_chk("s3_red0", 4'b0000, 1'b0);
        green_phase("s3_l2a", 4'b0010);
        green_phase("s3_l4", 4'b1000);
        step_chk("s3_l2b", 4'b0010, 1'b0);
        chk_lane("s3_lane", 2'd1);

        // Scenario 4: emergency during lane 2 green, lane 2 is not resumed
        bus.car_present = 4'b1111;
        do_reset();
        step_chk("s4_red0", 4'b0000, 1'b0);
        green_phase("s4_l1", 4'b0001);
        for (int i = 0; i < 4; i++) step_chk("s4_l2", 4'b0010, 1'b0);
        bus.emergency = 1'b1;
        for (int i = 0; i < 3; i++) step_chk("s4_emerg", 4'b0000, 1'b0);
        bus.emergency = 1'b0;
        for (int i = 0; i < 2; i++) step_chk("s4_clear", 4'b0000, 1'b0);
        step_chk("s4_l3", 4'b0100, 1'b0);
        chk_lane("s4_lane", 2'd2);

        // Scenario 5: en low during almost_done freezes the phase
        for (int i = 2; i <= 7; i++) step_chk("s5_l3", 4'b0100, (i >= 7));
        bus.en = 1'b0;
        for (int i = 0; i < 5; i++) step_chk("s5_frozen", 4'b0100, 1'b1);
        bus.en = 1'b1;
        step_chk("s5_last", 4'b0100, 1'b1);
        for (int i = 0; i < 2; i++) step_chk("s5_red", 4'b0000, 1'b0);
        step_chk("s5_l4", 4'b1000, 1'b0);

        // Scenario 6: asynchronous reset mid-green, no clock edge needed
        step_chk("s6_l4", 4'b1000, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("s6_async", 4'b0000, 1'b0);
        chk_lane("s6_async_lane", 2'd3);
        @(negedge clk);
        rst_n = 1'b1;
        chk("s6_held", 4'b0000, 1'b0);
        step_chk("s6_red0", 4'b0000, 1'b0);
        green_phase("s6_l1", 4'b0001);
        step_chk("s6_l2", 4'b0010, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/traffic_phase_controller.md
Name: traffic_phase_controller

Overview:
- Sequential controller that generates the 4-bit one-hot phase code and the almost_done indication consumed by the LED actuator of the 4-way intersection.
- Rotates green right-of-way among lanes 1..4 and inserts an all-red clearance interval between phases.
- Skips lanes with no vehicle demand and supports an emergency all-red override.
- Sits between the lane sensors/top level and the actuator; outputs are registered.

Parameters:
- GREEN_CYCLES, 8: total cycles a lane holds right-of-way (green + yellow portion); must be >= 2.
- YELLOW_CYCLES, 2: final cycles of a green phase during which almost_done=1; 1 <= YELLOW_CYCLES < GREEN_CYCLES.
- ALL_RED_CYCLES, 2: clearance cycles with state=4'b0000 between phases; must be >= 1.
- CNT_W, 8: phase counter width; must hold max(GREEN_CYCLES, ALL_RED_CYCLES)-1.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  advance enable; 0 freezes counter, FSM and outputs.
- car_present  input  4  per-lane demand; bit i corresponds to lane i+1, level-sensitive, synchronous to clk.
- emergency  input  1  level request forcing all-red.
- state  output  4  one-hot green lane (0001=L1, 0010=L2, 0100=L3, 1000=L4); 0000=all red.
- almost_done  output  1  1 during the last YELLOW_CYCLES cycles of a green phase.
- lane_idx  output  2  index of the last lane granted green; diagnostic.

Behaviour:
- FSM states: CLEAR, GREEN, EMERG. Registers: fsm, cnt[CNT_W], lane_idx[2], state, almost_done.
- Async reset: fsm=CLEAR, cnt=ALL_RED_CYCLES-1, lane_idx=3, state=0000, almost_done=0. Reset asserted mid-phase aborts immediately to these values.
- en=0 and emergency=0: all registers hold their values.
- CLEAR, state=0000, almost_done=0:
  - cnt!=0: decrement.
  - cnt==0: select the next lane in the rotation (lane_idx+1 mod 4, then +2, +3, +4) whose car_present bit is 1.
  - If no lane has demand, take lane_idx+1 mod 4.
  - Load lane_idx with the selected lane, set state=one-hot(selected lane), cnt=GREEN_CYCLES-1, fsm=GREEN.
  - The current lane is selectable again only as the +4 candidate, i.e. when it is the only lane with demand.
- GREEN, state one-hot:
  - cnt!=0: decrement.
  - almost_done is registered to equal (next cnt < YELLOW_CYCLES) while in GREEN. Result: green phase lasts GREEN_CYCLES cycles; almost_done is high for exactly the final YELLOW_CYCLES of them.
  - cnt==0: state=0000, almost_done=0, cnt=ALL_RED_CYCLES-1, fsm=CLEAR.
- First green after reset release: state=0001 on the ALL_RED_CYCLES-th rising edge. Lane 1 is granted if it has demand or no lane has demand.
- EMERG:
  - Entered on the edge where emergency=1, from any state regardless of en. Sets state=0000, almost_done=0.
  - Held while emergency=1.
  - On the first edge with emergency=0: cnt=ALL_RED_CYCLES-1, fsm=CLEAR. The normal clearance follows, then rotation resumes from lane_idx+1 with demand.
  - The interrupted lane's green is not resumed.
- Simultaneous events: emergency beats en and any phase transition. A car_present change takes effect only at the CLEAR->GREEN selection edge.
- state is always one-hot or zero. almost_done=1 only when state!=0000.

Test Plan:
- Reset release, car_present=4'b1111, en=1, defaults -> state=0000 for 2 cycles, then 0001 for 8 cycles with almost_done=1 on cycles 7-8, then 0000 x2, 0010, 0100, 1000, 0001.
- car_present=4'b0100 constant -> only 0100 green phases, each separated by 2 all-red cycles; lane_idx stays 2.
- car_present=4'b1010 starting from lane_idx=3 -> green order 0010, 1000, 0010; lanes 1 and 3 skipped.
- emergency pulsed high for 3 cycles at green cycle 4 of lane 2 -> state=0000 and almost_done=0 on the next edge, held 3 cycles, then 2 clearance cycles, then 0100 (lane 2 is not resumed).
- en=0 for 5 cycles during almost_done=1 -> state, almost_done and cnt frozen; the phase completes its remaining cycles after en=1.
- rst_n asserted asynchronously mid-green -> state=0000, almost_done=0, lane_idx=3 immediately without a clock edge; restart matches scenario 1.
